uart_recv: RTL and testbench

Serial-to-parallel UART receive stage; the downstream partner of `uart_trans` on the serial line. It recovers start, data and stop bits from `RX_serial` and presents each completed character on `RX_BYTE` with a one-cycle `RX_DV` strobe. Frame format (5–8 data bits, 1 or 2 stop bits, no parity) and bit rate (`clk_freq/uart_baud`) are run-time inputs, matching the transmitter's configuration scheme.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_sync2.sv | 30 +++
 rtl/uart_recv.sv | 191 +++++++++++++++++++
 tb/tb_uart_recv.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive stages.
//   - Width constants for the run-time configuration ports.
//   - FSM state encoding, common to uart_trans and uart_recv.
//   - Helpers that normalise the frame format and mask unused data bits.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned CLK_FREQ_W = 26;
   localparam int unsigned BAUD_W     = 20;
   localparam int unsigned CPB_W      = 14;
   localparam int unsigned DATA_W     = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'b000,
      START_BIT = 3'b001,
      DATA_BITS = 3'b010,
      STOP_BITS = 3'b011,
      CLEAN_UP  = 3'b100
   } uart_state_e;

   // Unsupported data-bit counts fall back to a full byte.
   function automatic logic [3:0] eff_data_bits(input logic [3:0] req);
      if (req >= 4'd5 && req <= 4'd8) begin
         return req;
      end
      return 4'd8;
   endfunction

   // Zero every bit at or above position nbits (nbits is 5..8).
   function automatic logic [DATA_W-1:0] mask_data(input logic [DATA_W-1:0] data,
                                                    input logic [3:0]        nbits);
      logic [DATA_W-1:0] mask;
      mask = 8'hFF >> (4'd8 - nbits);
      return data & mask;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to 1
// so an idle-high line does not look like a start edge coming out of reset.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   d      - asynchronous input
//   q      - synchronized output, 2 cycles of latency
// -----------------------------------------------------------------------------
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_recv.sv
// -----------------------------------------------------------------------------
// uart_recv
// UART receive stage. Recovers start, data (5..8, LSB first) and stop (1 or 2)
// bits from the serial line, sampling at bit centres, and presents each good
// character on RX_BYTE with a one-cycle RX_DV strobe. A low stop bit produces a
// one-cycle RX_Frame_Err strobe instead and leaves RX_BYTE untouched.
// Ports:
//   clk, rst_n    - system clock, asynchronous active-low reset
//   clk_freq      - system clock frequency in Hz
//   uart_baud     - bit rate; clocks per bit = clk_freq / uart_baud (truncated)
//   data_bits_rx  - data bits per frame (5..8, anything else means 8)
//   stop_bits_rx  - stop bits (2 means two, anything else means one)
//   RX_serial     - asynchronous serial input, idle high
//   RX_BYTE       - last good character, unused upper bits zero
//   RX_DV         - one-cycle strobe, RX_BYTE newly valid
//   RX_Frame_Err  - one-cycle strobe, a stop bit was sampled low
//   RX_Active     - high from start-bit confirmation until CLEAN_UP
// -----------------------------------------------------------------------------
module uart_recv
   import uart_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CLK_FREQ_W-1:0] clk_freq,
   input  logic [BAUD_W-1:0]     uart_baud,
   input  logic [3:0]            data_bits_rx,
   input  logic [1:0]            stop_bits_rx,
   input  logic                  RX_serial,
   output logic [DATA_W-1:0]     RX_BYTE,
   output logic                  RX_DV,
   output logic                  RX_Frame_Err,
   output logic                  RX_Active
);

   // ---------------------------------------------------------------------------
   // Line synchronization and edge history
   // ---------------------------------------------------------------------------
   logic rx_s;
   logic rx_prev;

   uart_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (RX_serial),
      .q     (rx_s)
   );

   // ---------------------------------------------------------------------------
   // Live configuration, captured into the frame registers on start detection
   // ---------------------------------------------------------------------------
   logic [CPB_W-1:0] cpb_now;
   logic [3:0]       nbits_now;
   logic             two_stop_now;

   always_comb begin
      cpb_now      = CPB_W'(clk_freq / CLK_FREQ_W'(uart_baud));
      nbits_now    = eff_data_bits(data_bits_rx);
      two_stop_now = (stop_bits_rx == 2'd2);
   end

   // ---------------------------------------------------------------------------
   // Frame state
   // ---------------------------------------------------------------------------
   uart_state_e       state;
   logic [CPB_W-1:0]  clk_cnt;
   logic [2:0]        bit_idx;
   logic              stop_idx;
   logic [CPB_W-1:0]  cpb_lat;
   logic [3:0]        nbits_lat;
   logic              two_stop_lat;
   logic [DATA_W-1:0] shreg;
   logic              stop_err;

   logic [CPB_W-1:0]  cpb_last;
   logic [CPB_W-1:0]  half_cnt;
   logic              last_data_bit;
   logic              start_edge;

   always_comb begin
      cpb_last      = cpb_lat - CPB_W'(1);
      half_cnt      = cpb_last >> 1;
      last_data_bit = ({1'b0, bit_idx} == (nbits_lat - 4'd1));
      start_edge    = rx_prev & ~rx_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rx_prev      <= 1'b1;
         clk_cnt      <= '0;
         bit_idx      <= '0;
         stop_idx     <= 1'b0;
         cpb_lat      <= '0;
         nbits_lat    <= 4'd8;
         two_stop_lat <= 1'b0;
         shreg        <= '0;
         stop_err     <= 1'b0;
         RX_BYTE      <= '0;
         RX_DV        <= 1'b0;
         RX_Frame_Err <= 1'b0;
         RX_Active    <= 1'b0;
      end else begin
         rx_prev      <= rx_s;
         // Strobes are high only in the cycle after CLEAN_UP decides them.
         RX_DV        <= 1'b0;
         RX_Frame_Err <= 1'b0;

         case (state)
            IDLE: begin
               clk_cnt  <= '0;
               bit_idx  <= '0;
               stop_idx <= 1'b0;
               stop_err <= 1'b0;
               // Edge, not level: a line stuck low never retriggers.
               if (start_edge) begin
                  cpb_lat      <= cpb_now;
                  nbits_lat    <= nbits_now;
                  two_stop_lat <= two_stop_now;
                  state        <= START_BIT;
               end
            end

            START_BIT: begin
               if (clk_cnt == half_cnt) begin
                  clk_cnt <= '0;
                  if (!rx_s) begin
                     RX_Active <= 1'b1;
                     state     <= DATA_BITS;
                  end else begin
                     // Too short to be a start bit: drop it without a strobe.
                     state <= IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CPB_W'(1);
               end
            end

            DATA_BITS: begin
               if (clk_cnt == cpb_last) begin
                  clk_cnt        <= '0;
                  shreg[bit_idx] <= rx_s;
                  if (last_data_bit) begin
                     bit_idx <= '0;
                     state   <= STOP_BITS;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CPB_W'(1);
               end
            end

            STOP_BITS: begin
               if (clk_cnt == cpb_last) begin
                  clk_cnt <= '0;
                  if (!rx_s) begin
                     stop_err <= 1'b1;
                  end
                  // stop_idx reaches two_stop_lat on the final stop sample.
                  if (stop_idx == two_stop_lat) begin
                     state <= CLEAN_UP;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CPB_W'(1);
               end
            end

            CLEAN_UP: begin
               if (stop_err) begin
                  RX_Frame_Err <= 1'b1;
               end else begin
                  RX_BYTE <= mask_data(shreg, nbits_lat);
                  RX_DV   <= 1'b1;
               end
               RX_Active <= 1'b0;
               stop_idx  <= 1'b0;
               stop_err  <= 1'b0;
               clk_cnt   <= '0;
               state     <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_recv.sv
// -----------------------------------------------------------------------------
// tb_uart_recv
// Bench for uart_recv. The bench itself frames characters onto RX_serial,
// pushes the expected outcome of each frame into a scoreboard queue, and a
// negedge monitor pops and compares every RX_DV / RX_Frame_Err strobe.
// -----------------------------------------------------------------------------
module tb_uart_recv;

   localparam int MAIN_FREQ = 50_000_000;
   localparam int MAIN_BAUD = 115200;
   localparam int CPB       = MAIN_FREQ / MAIN_BAUD;   // 434

   logic        clk = 1'b0;
   logic        rst_n;
   logic [25:0] clk_freq;
   logic [19:0] uart_baud;
   logic [3:0]  data_bits_rx;
   logic [1:0]  stop_bits_rx;
   logic        RX_serial;
   logic [7:0]  RX_BYTE;
   logic        RX_DV;
   logic        RX_Frame_Err;
   logic        RX_Active;

   always #5 clk = ~clk;

   uart_recv dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clk_freq     (clk_freq),
      .uart_baud    (uart_baud),
      .data_bits_rx (data_bits_rx),
      .stop_bits_rx (stop_bits_rx),
      .RX_serial    (RX_serial),
      .RX_BYTE      (RX_BYTE),
      .RX_DV        (RX_DV),
      .RX_Frame_Err (RX_Frame_Err),
      .RX_Active    (RX_Active)
   );

   typedef struct {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      int         freq;
      int         baud;
      logic [3:0] dbits;
      logic [1:0] sbits;
      logic [7:0] data;
      logic [1:0] stopv;   // bit j = level driven on stop bit j
   } vec_t;

   exp_t       sb[$];
   int         n_checks    = 0;
   int         n_pass      = 0;
   int         cyc         = 0;
   int         dv_count    = 0;
   int         err_count   = 0;
   int         last_dv_cyc = 0;
   logic       active_seen = 1'b0;
   logic [7:0] last_good   = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Scoreboard consumer.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (RX_Active) active_seen = 1'b1;
         if (RX_DV || RX_Frame_Err) begin
            check("dv/err exclusive", 32'(RX_DV & RX_Frame_Err), 0);
            if (RX_DV) begin
               dv_count++;
               last_dv_cyc = cyc;
            end
            if (RX_Frame_Err) err_count++;
            if (sb.size() == 0) begin
               check("strobe expected by scoreboard", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               check("strobe kind (1=frame err)", 32'(RX_Frame_Err), 32'(e.is_err));
               if (!e.is_err) begin
                  check("rx byte", 32'(RX_BYTE), 32'(e.data));
                  last_good = e.data;
               end else begin
                  check("rx byte kept on frame err", 32'(RX_BYTE), 32'(last_good));
               end
            end
         end
      end
   end

   // All waits start and end 1ns after a rising edge.
   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int freq, input int baud, input logic [3:0] db,
                          input logic [1:0] s);
      clk_freq     = 26'(freq);
      uart_baud    = 20'(baud);
      data_bits_rx = db;
      stop_bits_rx = s;
   endtask

   task automatic send_frame(input logic [7:0] b, input int n, input int s, input int cpb,
                             input logic [1:0] stopv);
      RX_serial = 1'b0;
      wait_clks(cpb);
      for (int i = 0; i < n; i++) begin
         RX_serial = b[i];
         wait_clks(cpb);
      end
      for (int j = 0; j < s; j++) begin
         RX_serial = stopv[j];
         wait_clks(cpb);
      end
      RX_serial = 1'b1;
   endtask

   task automatic push_exp(input logic is_err, input logic [7:0] data);
      exp_t e;
      e.is_err = is_err;
      e.data   = data;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input string name, input int limit);
      for (int i = 0; i < limit && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check(name, sb.size(), 0);
   endtask

   function automatic int eff_n(input logic [3:0] d);
      if (d >= 4'd5 && d <= 4'd8) return int'(d);
      return 8;
   endfunction

   function automatic int eff_s(input logic [1:0] s);
      return (s == 2'd2) ? 2 : 1;
   endfunction

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d",
               n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[8];
      int         dv0, err0, start_cyc, lat, n, s, cpb;
      logic       bad;
      logic [7:0] m;

      vecs[0] = '{1_000_000, 100_000, 4'd8,  2'd1, 8'h5A, 2'b11};
      vecs[1] = '{1_000_000, 62_500,  4'd7,  2'd1, 8'hFF, 2'b11};
      vecs[2] = '{500_000,   125_000, 4'd6,  2'd2, 8'hAB, 2'b11};
      vecs[3] = '{1_000_000, 70_000,  4'd8,  2'd2, 8'h81, 2'b01};
      vecs[4] = '{1_000_000, 100_000, 4'd3,  2'd0, 8'hC3, 2'b11};
      vecs[5] = '{1_000_000, 100_000, 4'd12, 2'd3, 8'h96, 2'b11};
      vecs[6] = '{500_000,   125_000, 4'd5,  2'd1, 8'h0E, 2'b11};
      vecs[7] = '{1_000_000, 100_000, 4'd8,  2'd1, 8'h00, 2'b00};

      // Power-on reset.
      rst_n     = 1'b0;
      RX_serial = 1'b1;
      set_cfg(MAIN_FREQ, MAIN_BAUD, 4'd8, 2'd1);
      @(posedge clk);
      #1;
      wait_clks(3);
      check("reset RX_BYTE", 32'(RX_BYTE), 0);
      check("reset RX_DV", 32'(RX_DV), 0);
      check("reset RX_Frame_Err", 32'(RX_Frame_Err), 0);
      check("reset RX_Active", 32'(RX_Active), 0);
      rst_n = 1'b1;
      wait_clks(10);

      // 8N1 0xA5.
      err0 = err_count;
      push_exp(1'b0, 8'hA5);
      send_frame(8'hA5, 8, 1, CPB, 2'b11);
      wait_drain("8N1 drain", 2000);
      check("8N1 no frame err", err_count, err0);
      check("8N1 active cleared", 32'(RX_Active), 0);
      check("8N1 active seen", 32'(active_seen), 1);
      wait_clks(2 * CPB);

      // 5 data bits, 2 stop bits, latency from line fall to RX_DV.
      set_cfg(MAIN_FREQ, MAIN_BAUD, 4'd5, 2'd2);
      push_exp(1'b0, 8'h1F);
      start_cyc = cyc;
      send_frame(8'hFF, 5, 2, CPB, 2'b11);
      wait_drain("5N2 drain", 2000);
      lat = last_dv_cyc - start_cyc;
      check("5N2 latency near 3259", 32'((lat >= 3245 && lat <= 3273) ? 1 : 0), 1);
      wait_clks(2 * CPB);

      // Start glitch.
      set_cfg(MAIN_FREQ, MAIN_BAUD, 4'd8, 2'd1);
      active_seen = 1'b0;
      dv0  = dv_count;
      err0 = err_count;
      RX_serial = 1'b0;
      wait_clks(100);
      RX_serial = 1'b1;
      wait_clks(2 * CPB);
      check("glitch RX_Active never set", 32'(active_seen), 0);
      check("glitch fsm idle", 32'(dut.state), 0);
      check("glitch no RX_DV", dv_count, dv0);
      check("glitch no frame err", err_count, err0);

      // Good 0x11, then 0x3C with a low stop bit.
      dv0  = dv_count;
      err0 = err_count;
      push_exp(1'b0, 8'h11);
      send_frame(8'h11, 8, 1, CPB, 2'b11);
      wait_clks(CPB);
      push_exp(1'b1, 8'h00);
      send_frame(8'h3C, 8, 1, CPB, 2'b00);
      wait_drain("bad stop drain", 2000);
      wait_clks(2 * CPB);
      check("bad stop err pulses", err_count - err0, 1);
      check("bad stop dv pulses", dv_count - dv0, 1);
      check("bad stop RX_BYTE kept", 32'(RX_BYTE), 32'h11);

      // Reset in the middle of data bit 4, then a clean 0x3C.
      m = 8'h3C;
      RX_serial = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 4; i++) begin
         RX_serial = m[i];
         wait_clks(CPB);
      end
      RX_serial = m[4];
      wait_clks(CPB / 2);
      check("active before reset", 32'(RX_Active), 1);
      rst_n = 1'b0;
      #1;
      last_good = 8'h00;
      check("mid reset RX_BYTE", 32'(RX_BYTE), 0);
      check("mid reset RX_DV", 32'(RX_DV), 0);
      check("mid reset RX_Frame_Err", 32'(RX_Frame_Err), 0);
      check("mid reset RX_Active", 32'(RX_Active), 0);
      RX_serial = 1'b1;
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(3 * CPB);
      check("after reset no strobe", dv_count, dv0 + 1);
      push_exp(1'b0, 8'h3C);
      send_frame(8'h3C, 8, 1, CPB, 2'b11);
      wait_drain("post-reset drain", 2000);
      wait_clks(2 * CPB);

      // Back-to-back 8N1 with no idle gap.
      err0 = err_count;
      dv0  = dv_count;
      push_exp(1'b0, 8'h00);
      push_exp(1'b0, 8'hFF);
      send_frame(8'h00, 8, 1, CPB, 2'b11);
      send_frame(8'hFF, 8, 1, CPB, 2'b11);
      wait_drain("back-to-back drain", 2000);
      check("back-to-back dv pulses", dv_count - dv0, 2);
      check("back-to-back no frame err", err_count, err0);
      wait_clks(2 * CPB);

      // Table of formats and rates, including out-of-range configuration.
      for (int k = 0; k < 8; k++) begin
         n   = eff_n(vecs[k].dbits);
         s   = eff_s(vecs[k].sbits);
         cpb = vecs[k].freq / vecs[k].baud;
         bad = 1'b0;
         for (int j = 0; j < s; j++) begin
            if (!vecs[k].stopv[j]) bad = 1'b1;
         end
         m = vecs[k].data & 8'((1 << n) - 1);
         set_cfg(vecs[k].freq, vecs[k].baud, vecs[k].dbits, vecs[k].sbits);
         wait_clks(3 * cpb);
         push_exp(bad, m);
         send_frame(vecs[k].data, n, s, cpb, vecs[k].stopv);
         wait_drain($sformatf("vector %0d drain", k), 200);
         wait_clks(3 * cpb);
      end

      check("scoreboard empty at end", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
